// File: rtl/id_fetch_queue.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module  : id_fetch_queue
// Brief   : DEPTH-entry in-order fetch queue with pipelined imem reads,
//           flush-safe stale-response dropping and optional head bypass.
// Revision: 1.0
//-----------------------------------------------------------------------------
module id_fetch_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int BYPASS          = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [31:0]              req_pc,
  output logic                     req_ready,
  output logic [31:0]              imem_addr,
  output logic [3:0]               imem_rmask,
  input  logic                     imem_resp,
  input  logic [31:0]              imem_rdata,
  input  logic                     i_flush,
  output logic                     o_valid,
  output logic [31:0]              o_inst,
  output logic [31:0]              o_pc,
  output logic [63:0]              o_order,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_imem_stall
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          PW        = AW + 1;
  localparam int          DW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] C_NOP     = 32'h0000_0013;
  localparam logic [31:0] C_DEPTH   = 32'(DEPTH);
  localparam logic [31:0] C_MAX_OUT = 32'(MAX_OUTSTANDING);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_fill_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [DW-1:0] r_drop;
  logic [63:0]   r_order;
  logic [31:0]   r_pc   [DEPTH];
  logic [31:0]   r_inst [DEPTH];

  logic [PW-1:0] w_alloc;
  logic [PW-1:0] w_pend;
  logic [PW-1:0] w_filled;
  logic [31:0]   w_busy;
  logic          w_ready;
  logic          w_fire;
  logic          w_resp_ok;
  logic          w_drop;
  logic          w_fill;
  logic          w_bypass;
  logic          w_valid;
  logic          w_pop;
  logic [DW-1:0] w_drop_flush;
  logic [AW-1:0] w_rd_idx;

  // Pointer differences modulo 2*DEPTH; the wrap bit separates full from empty.
  assign w_alloc  = r_wr_ptr - r_rd_ptr;
  assign w_pend   = r_wr_ptr - r_fill_ptr;
  assign w_filled = r_fill_ptr - r_rd_ptr;
  assign w_busy   = 32'(w_pend) + 32'(r_drop);
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  assign w_ready   = !i_flush && (32'(w_alloc) < C_DEPTH) && (w_busy < C_MAX_OUT);
  assign w_fire    = req_valid && w_ready;
  assign w_resp_ok = imem_resp && (w_busy != 32'd0);
  assign w_drop    = w_resp_ok && (r_drop != '0);
  assign w_fill    = w_resp_ok && (r_drop == '0);

  assign w_bypass = (BYPASS != 0) && (w_pend != '0) && (r_drop == '0) && imem_resp &&
                    (r_fill_ptr == r_rd_ptr);
  assign w_valid  = !i_flush && ((w_filled != '0) || w_bypass);
  assign w_pop    = w_valid && i_ready;

  // Every live read becomes stale; a response in this same cycle retires one of them.
  assign w_drop_flush = DW'(32'(r_drop) + 32'(w_pend) - 32'(w_resp_ok));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_fill_ptr <= '0;
      r_rd_ptr   <= '0;
      r_drop     <= '0;
      r_order    <= 64'd0;
    end else if (i_flush) begin
      r_wr_ptr   <= '0;
      r_fill_ptr <= '0;
      r_rd_ptr   <= '0;
      r_drop     <= w_drop_flush;
    end else begin
      if (w_fire) r_wr_ptr   <= r_wr_ptr + PW'(1);
      if (w_fill) r_fill_ptr <= r_fill_ptr + PW'(1);
      if (w_drop) r_drop     <= r_drop - DW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_order  <= r_order + 64'd1;
      end
    end
  end

  // A bypassed response is also written; the slot is released by the same pop.
  always_ff @(posedge clk) begin
    if (w_fire) r_pc[r_wr_ptr[AW-1:0]]     <= req_pc;
    if (w_fill) r_inst[r_fill_ptr[AW-1:0]] <= imem_rdata;
  end

  assign req_ready    = w_ready;
  assign imem_addr    = req_pc;
  assign imem_rmask   = w_fire ? 4'hF : 4'h0;
  assign o_valid      = w_valid;
  assign o_inst       = !w_valid ? C_NOP : ((w_filled != '0) ? r_inst[w_rd_idx] : imem_rdata);
  assign o_pc         = w_valid ? r_pc[w_rd_idx] : 32'd0;
  assign o_order      = r_order;
  assign o_count      = w_alloc;
  assign o_imem_stall = !w_valid && (w_pend != '0);

  a_resp_has_owner : assert property (@(posedge clk) disable iff (rst)
    imem_resp |-> (w_busy != 32'd0));

endmodule
`default_nettype wire

// File: doc/id_fetch_queue.md
# id_fetch_queue

Parametrised instruction fetch queue between the instruction memory port and the decode stage. It replaces the single-entry stall buffer with a DEPTH-entry in-order queue and issues up to MAX_OUTSTANDING pipelined imem reads. Each queue entry is reserved when its read is issued, so a response always has space. On a flush it discards every queued and in-flight instruction by counting stale responses. It presents instructions with their PC and RVFI order to decode under a valid/ready handshake.

## Interface
- DEPTH, 4, queue entries; power of two, >= 2
- MAX_OUTSTANDING, 2, maximum imem reads in flight; 1..DEPTH
- BYPASS, 1, 1: a response landing at an empty head is presented to decode in the same cycle; 0: it is presented the cycle after it is written
- Reset: rst is synchronous and active-high; the clock is clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  fetch stage requests a read at req_pc
- req_pc  in  32  fetch address
- req_ready  out  1  read may issue this cycle
- imem_addr  out  32  equals req_pc
- imem_rmask  out  4  4'hF when a read fires, else 4'h0
- imem_resp  in  1  in-order read response
- imem_rdata  in  32  response data
- i_flush  in  1  redirect; kill all queued and in-flight instructions
- o_valid  out  1  head instruction available
- o_inst  out  32  head instruction; 32'h0000_0013 (NOP) when o_valid=0
- o_pc  out  32  PC of the head instruction
- o_order  out  64  RVFI order of the head instruction
- i_ready  in  1  decode accepts; driven as !id_stall && !load_hazard
- o_count  out  clog2(DEPTH)+1  number of allocated entries, filled or pending
- o_imem_stall  out  1  o_valid=0 while at least one non-stale read is in flight

## Operation
- State:
  - wr_ptr, fill_ptr and rd_ptr, each clog2(DEPTH)+1 bits with a wrap bit.
  - Per-entry pc and inst.
  - drop_cnt, clog2(MAX_OUTSTANDING+1) bits.
  - order, 64 bits.
- Derived counts:
  - alloc = wr_ptr - rd_ptr, range 0..DEPTH.
  - pend = wr_ptr - fill_ptr, the live in-flight reads.
  - filled = fill_ptr - rd_ptr.
- Issue:
  - req_ready = !i_flush && alloc < DEPTH && (pend + drop_cnt) < MAX_OUTSTANDING.
  - A read fires when req_valid && req_ready.
  - On fire, pc[wr_ptr] <= req_pc and wr_ptr increments.
- Response:
  - If drop_cnt > 0, drop_cnt decrements and the data is discarded.
  - Otherwise inst[fill_ptr] <= imem_rdata and fill_ptr increments.
  - A response with pend + drop_cnt = 0 is a protocol error: it is ignored and flagged by an assertion.
- Head valid:
  - o_valid = !i_flush && (filled > 0 || (BYPASS && pend > 0 && drop_cnt == 0 && imem_resp && fill_ptr == rd_ptr)).
  - In the bypass case o_inst = imem_rdata.
- Pop:
  - A pop occurs on o_valid && i_ready.
  - On pop, rd_ptr and order increment.
  - A bypass pop also increments fill_ptr; the entry write is harmless.
- Flush:
  - Sets wr_ptr, fill_ptr and rd_ptr to 0.
  - Sets drop_cnt <= drop_cnt + pend - (imem_resp ? 1 : 0).
  - A response arriving in the flush cycle counts as consumed.
  - No issue and no pop can occur in the flush cycle.
  - order is not changed by a flush.
- o_imem_stall = !o_valid && pend > 0.

## Timing
- Reset values:
  - All pointers, drop_cnt and order are 0.
  - o_valid=0, o_inst=32'h13, o_pc=0, o_order=0, o_count=0, req_ready=1, imem_rmask=0, o_imem_stall=0.
- Issue-to-response latency is at least one cycle. A response in the same cycle as a fire belongs to an earlier read.
- Fill-to-valid latency:
  - BYPASS=1: 0 cycles at an empty head.
  - Otherwise: 1 cycle.
- Simultaneous events:
  - Fire, response and pop may all occur in one cycle, and the pointers update independently.
  - At alloc = DEPTH, a pop in the same cycle does not make req_ready high. req_ready is computed from registered state.
- Reset while reads are in flight: drop_cnt is cleared. The memory side is reset by the same rst, so no stale responses follow.
- Wrap-around: pointers wrap modulo 2*DEPTH, and full and empty are distinguished by the wrap bit.

## Test plan
- Reset, then req_valid=1 with PCs 0x0, 0x4, 0x8 and i_ready=1, memory latency 1 -> three reads fire; o_inst appears with o_pc 0x0, 0x4, 0x8 and o_order 0, 1, 2.
- i_ready=0, DEPTH=4, continuous requests -> exactly 4 reads fire, req_ready=0, o_count=4; release i_ready -> one pop per cycle and req_ready is high again the next cycle.
- Two reads in flight, i_flush pulsed -> drop_cnt=2 and the next two responses are discarded; the read to the new PC 0x100 is presented with o_order continuing from its pre-flush value.
- Flush in the same cycle as a response, with 2 in flight -> drop_cnt=1; no instruction from before the flush is ever presented.
- BYPASS=1 with an empty queue, response 0x00500093 -> o_valid=1 with o_inst=0x00500093 in the response cycle. BYPASS=0 -> the instruction is presented the following cycle.
- Pointer wrap over 20 cycles with random i_ready -> the PC and instruction sequence matches a reference model and o_order is contiguous.
